// File: rtl/pve_pkg.sv
// Shared constants, state encoding and sizing helper
// for the part vector engine.
package pve_pkg;

   localparam logic [7:0] CMD_APPLY = 8'h41;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_CLEAR = 8'h43;

   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_BAD   = 8'h3F;
   localparam logic [7:0] RSP_PASS  = 8'h2E;
   localparam logic [7:0] RSP_FAIL  = 8'h46;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_PI,
      ST_LD_EXP,
      ST_LD_MSK,
      ST_SETTLE,
      ST_CMP,
      ST_TX
   } state_t;

   // Number of whole bytes needed to carry a w-bit field.
   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/part_vector_engine_bit_sync.sv
// Two-flop synchroniser for a bus of independent
// asynchronous bits.
module bit_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;

   // Two stages to let metastability resolve.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/part_vector_engine.sv
// Byte-command driven test-vector engine: loads PI/expected/mask
// vectors, drives the part, compares its outputs, reports over UART.
module part_vector_engine
   import pve_pkg::*;
#(
   parameter int NPIS   = 14,
   parameter int NPOS   = 11,
   parameter int SETTLE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic [7:0]      tx_data,
   output logic            tx_start,
   input  logic            tx_ready,
   output logic [NPIS-1:0] part_pis_o,
   input  logic [NPOS-1:0] part_pos_i,
   output logic            busy,
   output logic            overrun,
   output logic [15:0]     vec_cnt,
   output logic [15:0]     fail_cnt
);

   localparam int NIB = nbytes(NPIS);
   localparam int NOB = nbytes(NPOS);
   localparam int TXB = (NOB + 1 > 4) ? NOB + 1 : 4;
   localparam int SW  = $clog2(SETTLE + 1);

   localparam logic [3:0]    NIB_LAST = 4'(NIB - 1);
   localparam logic [3:0]    NOB_LAST = 4'(NOB - 1);
   localparam logic [3:0]    FAIL_LEN = 4'(NOB + 1);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

   if (SETTLE < 2) begin : g_settle_chk
      $error("part_vector_engine: SETTLE must be at least 2");
   end
   if (NPIS < 1 || NPIS > 64 || NPOS < 1 || NPOS > 64) begin : g_width_chk
      $error("part_vector_engine: NPIS/NPOS must be 1..64");
   end

   state_t             r_state;
   logic [3:0]         r_idx;
   logic [SW-1:0]      r_set_cnt;
   logic [NPIS-1:0]    r_pi;
   logic [NPOS-1:0]    r_exp;
   logic [NPOS-1:0]    r_msk;
   logic [NPOS-1:0]    r_po_cap;
   logic [15:0]        r_vec_cnt;
   logic [15:0]        r_fail_cnt;
   logic [TXB*8-1:0]   r_tx_buf;
   logic [3:0]         r_tx_left;

   logic [NPOS-1:0]    w_po_sync;
   logic [NPOS-1:0]    w_mism;
   logic [NPIS-1:0]    w_pi_rep;
   logic [NPIS-1:0]    w_pi_sel;
   logic [NPIS-1:0]    w_pi_nx;
   logic [NPOS-1:0]    w_po_rep;
   logic [NPOS-1:0]    w_po_sel;
   logic [NPOS-1:0]    w_exp_nx;
   logic [NPOS-1:0]    w_msk_nx;
   logic [TXB*8-1:0]   w_fail_buf;
   logic [TXB*8-1:0]   w_rd_buf;
   logic               w_drop;

   function automatic logic [TXB*8-1:0] one_byte(input logic [7:0] b);
      one_byte      = '0;
      one_byte[7:0] = b;
   endfunction

   bit_sync #(.WIDTH(NPOS)) u_po_sync (
      .clk (clk),
      .rst (rst),
      .i_d (part_pos_i),
      .o_q (w_po_sync)
   );

   // Merge the incoming byte into the field at the current byte index;
   // bits beyond the field width fall off, so padding is ignored.
   assign w_pi_rep = NPIS'({NIB{rx_data}});
   assign w_pi_sel = NPIS'(8'hFF) << {r_idx, 3'b000};
   assign w_pi_nx  = (r_pi & ~w_pi_sel) | (w_pi_rep & w_pi_sel);
   assign w_po_rep = NPOS'({NOB{rx_data}});
   assign w_po_sel = NPOS'(8'hFF) << {r_idx, 3'b000};
   assign w_exp_nx = (r_exp & ~w_po_sel) | (w_po_rep & w_po_sel);
   assign w_msk_nx = (r_msk & ~w_po_sel) | (w_po_rep & w_po_sel);

   assign w_mism = (r_po_cap ^ r_exp) & r_msk;
   assign w_drop = rx_valid && (r_state == ST_SETTLE ||
                                r_state == ST_CMP ||
                                r_state == ST_TX);

   // Response images, first byte to send in bits [7:0].
   always_comb begin
      w_fail_buf            = '0;
      w_fail_buf[7:0]       = RSP_FAIL;
      w_fail_buf[8 +: NPOS] = w_mism;
      w_rd_buf              = '0;
      w_rd_buf[31:0]        = {r_fail_cnt[7:0], r_fail_cnt[15:8],
                               r_vec_cnt[7:0], r_vec_cnt[15:8]};
   end

   // Command FSM with loaders, settle timer, compare and byte sender.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_set_cnt  <= '0;
         r_pi       <= '0;
         r_exp      <= '0;
         r_msk      <= '0;
         r_po_cap   <= '0;
         r_vec_cnt  <= '0;
         r_fail_cnt <= '0;
         r_tx_buf   <= '0;
         r_tx_left  <= '0;
         part_pis_o <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         overrun    <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (w_drop) overrun <= 1'b1;
         case (r_state)
            ST_IDLE: if (rx_valid) begin
               r_idx <= '0;
               case (rx_data)
                  CMD_APPLY: r_state <= ST_LD_PI;
                  CMD_READ: begin
                     r_tx_buf  <= w_rd_buf;
                     r_tx_left <= 4'd4;
                     r_state   <= ST_TX;
                  end
                  CMD_CLEAR: begin
                     r_vec_cnt  <= '0;
                     r_fail_cnt <= '0;
                     overrun    <= 1'b0;
                     r_tx_buf   <= one_byte(RSP_OK);
                     r_tx_left  <= 4'd1;
                     r_state    <= ST_TX;
                  end
                  default: begin
                     r_tx_buf  <= one_byte(RSP_BAD);
                     r_tx_left <= 4'd1;
                     r_state   <= ST_TX;
                  end
               endcase
            end
            ST_LD_PI: if (rx_valid) begin
               r_pi <= w_pi_nx;
               if (r_idx == NIB_LAST) begin
                  r_idx   <= '0;
                  r_state <= ST_LD_EXP;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end
            ST_LD_EXP: if (rx_valid) begin
               r_exp <= w_exp_nx;
               if (r_idx == NOB_LAST) begin
                  r_idx   <= '0;
                  r_state <= ST_LD_MSK;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end
            ST_LD_MSK: if (rx_valid) begin
               r_msk <= w_msk_nx;
               if (r_idx == NOB_LAST) begin
                  r_idx     <= '0;
                  r_set_cnt <= '0;
                  r_state   <= ST_SETTLE;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end
            ST_SETTLE: begin
               if (r_set_cnt == '0) part_pis_o <= r_pi;
               if (r_set_cnt == SET_LAST) begin
                  r_po_cap <= w_po_sync;
                  r_state  <= ST_CMP;
               end else begin
                  r_set_cnt <= r_set_cnt + 1'b1;
               end
            end
            ST_CMP: begin
               if (r_vec_cnt != 16'hFFFF) r_vec_cnt <= r_vec_cnt + 16'd1;
               if (|w_mism && r_fail_cnt != 16'hFFFF)
                  r_fail_cnt <= r_fail_cnt + 16'd1;
               r_tx_buf  <= |w_mism ? w_fail_buf : one_byte(RSP_PASS);
               r_tx_left <= |w_mism ? FAIL_LEN : 4'd1;
               r_state   <= ST_TX;
            end
            ST_TX: begin
               // Stay one cycle after the last start so busy covers it;
               // never start back-to-back so the UART can drop ready.
               if (r_tx_left == '0) begin
                  r_state <= ST_IDLE;
               end else if (tx_ready && !tx_start) begin
                  tx_start  <= 1'b1;
                  tx_data   <= r_tx_buf[7:0];
                  r_tx_buf  <= r_tx_buf >> 8;
                  r_tx_left <= r_tx_left - 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign vec_cnt  = r_vec_cnt;
   assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_part_vector_engine.sv
// Self-checking bench for part_vector_engine with part outputs
// looped back from the low stimulus bits.
module tb_part_vector_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_ready;
   logic [13:0] part_pis;
   logic [10:0] part_pos;
   logic        busy;
   logic        overrun;
   logic [15:0] vec_cnt;
   logic [15:0] fail_cnt;

   assign part_pos = part_pis[10:0];

   always #5 clk = ~clk;

   part_vector_engine #(.NPIS(14), .NPOS(11), .SETTLE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_ready   (tx_ready),
      .part_pis_o (part_pis),
      .part_pos_i (part_pos),
      .busy       (busy),
      .overrun    (overrun),
      .vec_cnt    (vec_cnt),
      .fail_cnt   (fail_cnt)
   );

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   int nstart = 0;
   logic prev_start = 1'b0;
   logic [7:0] txq[$];

   // Transmit-side monitor: collect bytes and police the start rules.
   always @(negedge clk) begin
      if (tx_start) begin
         txq.push_back(tx_data);
         nstart <= nstart + 1;
         if (!tx_ready || prev_start) viol <= viol + 1;
      end
      prev_start <= tx_start;
   end

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // Reference model: counters plus reply for one applied vector.
   int m_vec;
   int m_fail;

   task automatic model_apply(input logic [15:0] pi, ex, mk,
                              output int n, output logic [31:0] r);
      logic [10:0] mm;
      mm = (pi[10:0] ^ ex[10:0]) & mk[10:0];
      m_vec = (m_vec < 65535) ? m_vec + 1 : 65535;
      if (mm != 0) m_fail = (m_fail < 65535) ? m_fail + 1 : 65535;
      if (mm == 0) begin
         n = 1;
         r = 32'h2E;
      end else begin
         n = 3;
         r = {8'h00, 5'b0, mm, 8'h46};
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic get_reply(input int n, input logic [31:0] exp,
                            input string nm);
      logic [31:0] got;
      int k;
      k = 0;
      while (txq.size() < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      k = 0;
      while (busy && k < 200) begin
         @(posedge clk);
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({nm, " len"}, txq.size(), n);
      got = '0;
      for (int i = 0; i < txq.size() && i < 4; i++) got[8*i +: 8] = txq[i];
      check(nm, got, exp);
      check({nm, " idle"}, busy, 1'b0);
      txq.delete();
   endtask

   task automatic cmd(input logic [7:0] b, input int n,
                      input logic [31:0] exp, input string nm);
      txq.delete();
      send_byte(b);
      get_reply(n, exp, nm);
   endtask

   task automatic do_vec(input logic [15:0] pi, ex, mk, input bit inj,
                         output int lp, output int ls);
      txq.delete();
      send_byte(8'h41);
      send_byte(pi[7:0]);
      send_byte(pi[15:8]);
      send_byte(ex[7:0]);
      send_byte(ex[15:8]);
      send_byte(mk[7:0]);
      send_byte(mk[15:8]);
      lp = -1;
      ls = -1;
      if (inj) begin
         rx_data  = 8'h52;
         rx_valid = 1'b1;
      end
      for (int c = 1; c <= 60 && ls < 0; c++) begin
         @(posedge clk); #1;
         rx_valid = 1'b0;
         if (lp < 0 && part_pis == pi[13:0]) lp = c;
         if (tx_start) ls = c;
      end
   endtask

   typedef struct {
      logic [15:0] pi;
      logic [15:0] ex;
      logic [15:0] mk;
      int          n;
      logic [31:0] rsp;
   } vec_t;

   vec_t tbl[8];

   task automatic run_row(input int i);
      int lp, ls, n;
      logic [31:0] r;
      do_vec(tbl[i].pi, tbl[i].ex, tbl[i].mk, 1'b0, lp, ls);
      if (i == 0) begin
         check("pis latency", lp, 1);
         check("start latency", ls, 6);
      end
      get_reply(tbl[i].n, tbl[i].rsp, $sformatf("row%0d", i));
      check($sformatf("row%0d pis", i), part_pis, tbl[i].pi[13:0]);
      model_apply(tbl[i].pi, tbl[i].ex, tbl[i].mk, n, r);
      check($sformatf("row%0d vec", i), vec_cnt, m_vec);
      check($sformatf("row%0d fail", i), fail_cnt, m_fail);
   endtask

   initial begin
      int lp, ls, n, k, s;
      logic [15:0] pi, ex, mk;
      logic [31:0] r;
      logic [7:0]  jb;

      tbl[0] = '{16'h1234, 16'h0234, 16'h07FF, 1, 32'h0000002E};
      tbl[1] = '{16'h1234, 16'h0235, 16'h07FF, 3, 32'h00000146};
      tbl[2] = '{16'h1234, 16'h0235, 16'h07FE, 1, 32'h0000002E};
      tbl[3] = '{16'h3FFF, 16'h0000, 16'h07FF, 3, 32'h0007FF46};
      tbl[4] = '{16'h0000, 16'h07FF, 16'h0000, 1, 32'h0000002E};
      tbl[5] = '{16'h2AAA, 16'h0155, 16'h0700, 3, 32'h00030046};
      tbl[6] = '{16'h1234, 16'hF234, 16'hFFFF, 1, 32'h0000002E};
      tbl[7] = '{16'hC001, 16'h0001, 16'h07FF, 1, 32'h0000002E};

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      tx_ready = 1'b1;
      m_vec    = 0;
      m_fail   = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst pis", part_pis, 14'h0);
      check("rst tx_start", tx_start, 1'b0);
      check("rst tx_data", tx_data, 8'h0);
      check("rst busy", busy, 1'b0);
      check("rst overrun", overrun, 1'b0);
      check("rst vec", vec_cnt, 16'h0);
      check("rst fail", fail_cnt, 16'h0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) run_row(i);
      cmd(8'h52, 4, 32'h01000300, "read");
      cmd(8'h7A, 1, 32'h3F, "unknown");
      cmd(8'h43, 1, 32'h4B, "clear");
      m_vec  = 0;
      m_fail = 0;
      check("clear vec", vec_cnt, 16'h0);
      check("clear fail", fail_cnt, 16'h0);

      do_vec(16'h1234, 16'h0235, 16'h07FF, 1'b1, lp, ls);
      get_reply(3, 32'h00000146, "inject reply");
      model_apply(16'h1234, 16'h0235, 16'h07FF, n, r);
      check("overrun set", overrun, 1'b1);
      check("inject vec", vec_cnt, m_vec);
      cmd(8'h43, 1, 32'h4B, "clear2");
      m_vec  = 0;
      m_fail = 0;
      check("overrun clr", overrun, 1'b0);

      for (int i = 3; i < 8; i++) run_row(i);

      for (int t = 0; t < 40; t++) begin
         pi = 16'($urandom);
         ex = ($urandom_range(0, 1) == 1) ? pi : 16'($urandom);
         mk = 16'($urandom);
         do_vec(pi, ex, mk, 1'b0, lp, ls);
         model_apply(pi, ex, mk, n, r);
         get_reply(n, r, $sformatf("rnd%0d", t));
         if (t % 8 == 7) begin
            cmd(8'h52, 4,
                {8'(m_fail), 8'(m_fail >> 8), 8'(m_vec), 8'(m_vec >> 8)},
                $sformatf("rnd read%0d", t));
         end
         if (t % 10 == 5) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'h41 || jb == 8'h52 || jb == 8'h43) jb = 8'h00;
            cmd(jb, 1, 32'h3F, $sformatf("rnd junk%0d", t));
         end
      end

      do_vec(16'h0055, 16'h0000, 16'h07FF, 1'b1, lp, ls);
      model_apply(16'h0055, 16'h0000, 16'h07FF, n, r);
      get_reply(n, r, "pre-reset vec");
      txq.delete();
      send_byte(8'h41);
      send_byte(8'h34);
      rst = 1'b1;
      #2;
      check("mid rst pis", part_pis, 14'h0);
      check("mid rst tx_data", tx_data, 8'h0);
      check("mid rst tx_start", tx_start, 1'b0);
      check("mid rst busy", busy, 1'b0);
      check("mid rst overrun", overrun, 1'b0);
      check("mid rst vec", vec_cnt, 16'h0);
      check("mid rst fail", fail_cnt, 16'h0);
      @(posedge clk); #1;
      rst    = 1'b0;
      m_vec  = 0;
      m_fail = 0;
      run_row(0);

      force dut.r_vec_cnt = 16'hFFFF;
      force dut.r_fail_cnt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_vec_cnt;
      release dut.r_fail_cnt;
      m_vec  = 65535;
      m_fail = 65535;
      check("preload vec", vec_cnt, 16'hFFFF);
      txq.delete();
      send_byte(8'h41);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h35);
      send_byte(8'h02);
      send_byte(8'hFF);
      send_byte(8'h07);
      k = 0;
      while (txq.size() < 1 && k < 500) begin
         @(posedge clk);
         k++;
      end
      #1;
      tx_ready = 1'b0;
      s = nstart;
      repeat (100) @(posedge clk);
      #1;
      check("held no start", nstart - s, 0);
      check("held busy", busy, 1'b1);
      tx_ready = 1'b1;
      get_reply(3, 32'h00000146, "held reply");
      model_apply(16'h1234, 16'h0235, 16'h07FF, n, r);
      check("sat vec", vec_cnt, m_vec);
      check("sat fail", fail_cnt, m_fail);
      cmd(8'h52, 4, 32'hFFFFFFFF, "sat read");

      check("tx protocol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/part_vector_engine.md
# part_vector_engine

Parametrised test-vector engine, the successor to the fixed 14-in/11-out part tester command path. It consumes a byte stream from the UART receiver, assembles a stimulus/expected/mask vector of configurable width and drives the stimulus onto the part under test. After a programmable settle time it samples the part outputs through a synchroniser, compares them under the mask, and reports pass/fail plus the mismatch vector to the UART transmitter. Saturating vector and fail counters are kept on-chip and can be read back or cleared.

## Interface
- NPIS, 14: part input width, 1..64
- NPOS, 11: part output width, 1..64
- SETTLE, 4: clk cycles from the PI update to the PO capture; must be ≥ 2, enforced by an elaboration check
- Derived: NIB = ceil(NPIS/8), NOB = ceil(NPOS/8)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_ready  in  1  transmitter idle
- part_pis_o  out  NPIS  stimulus to the part
- part_pos_i  in  NPOS  part outputs, asynchronous to clk
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky; set when a byte is dropped
- vec_cnt  out  16  vectors applied, saturating
- fail_cnt  out  16  failing vectors, saturating

## Operation
- Command bytes accepted in IDLE:
  - 0x41 'A' apply: followed by NIB PI bytes, then NOB expected bytes, then NOB mask bytes.
  - 0x52 'R' read counters.
  - 0x43 'C' clear vec_cnt, fail_cnt and overrun; reply 0x4B 'K'.
  - Any other byte: reply 0x3F '?'.
- Byte order and packing:
  - All multi-byte fields are sent least-significant byte first.
  - Bit 0 of the field is bit 0 of the first byte.
  - Padding bits in the last byte are ignored.
- State sequence: IDLE → LD_PI → LD_EXP → LD_MSK → SETTLE → CMP → TX → IDLE. R and C go IDLE → TX.
- SETTLE:
  - On entry, part_pis_o loads the assembled PI vector.
  - A counter runs SETTLE cycles.
  - On the final cycle, the output of the 2-flop synchroniser on part_pos_i is captured into po_cap.
- CMP:
  - mism = (po_cap ^ exp) & msk.
  - vec_cnt increments.
  - If mism ≠ 0, fail_cnt increments.
  - Both counters hold at 0xFFFF.
- TX response:
  - Pass: 0x2E '.'.
  - Fail: 0x46 'F' followed by NOB mismatch bytes, LSB first.
  - R reply: vec_cnt[15:8], vec_cnt[7:0], fail_cnt[15:8], fail_cnt[7:0]. The snapshot is taken when the command is accepted.
- part_pis_o holds the last applied vector until the next apply or reset.
- A byte with rx_valid while in SETTLE, CMP or TX is dropped and sets overrun. Loading states accept every byte.
- Reset, including mid-command:
  - Reset values: part_pis_o=0, tx_start=0, tx_data=0, busy=0, overrun=0, counters=0, synchroniser=0, state IDLE.
  - Partially loaded vectors are discarded.

## Timing
- An rx_valid byte is registered in the same cycle; the state advances on the next edge.
- Last mask byte accepted at edge T:
  - part_pis_o changes at T+1.
  - po_cap is captured at T+SETTLE.
  - CMP runs at T+SETTLE+1.
  - The first tx_start is asserted no earlier than T+SETTLE+2.
- tx_start rules:
  - Asserted for exactly one cycle, only while tx_ready=1.
  - tx_data is stable in that cycle.
  - Never asserted in the cycle immediately after a previous tx_start, which gives the transmitter one cycle to drop tx_ready.
- busy drops in the cycle after the last byte's tx_start.
- A command byte arriving in the cycle busy falls is accepted.

## Structure
- Package pve_pkg:
  - command/response byte constants
  - state enum
  - NIB/NOB ceil-divide function
- Sub-module bit_sync: a 2-flop synchroniser with WIDTH parameter and async reset, used for part_pos_i.
- Everything else stays in one module: byte shift-in registers, FSM, byte index counter, settle counter, comparator, TX mux.

## Test plan
Defaults NPIS=14, NPOS=11, SETTLE=4; bench loops back part_pos_i = part_pis_o[10:0].
1. 'A', 0x34 0x12, exp 0x34 0x02, mask 0xFF 0x07 → part_pis_o=0x1234; reply '.'; vec_cnt=1, fail_cnt=0; tx_start 6 cycles after the last mask byte, with tx_ready held high.
2. Same vector with exp 0x35 0x02 → reply 'F',0x01,0x00; fail_cnt=1. Then mask 0xFE 0x07 → reply '.'.
3. 'R' → 0x00,0x03,0x00,0x01. Then 0x7A → '?'. Then 'C' → 'K'; counters=0.
4. Byte injected during SETTLE → byte dropped, overrun=1, response unchanged. Then 'C' → overrun=0.
5. rst pulsed after 'A' and the first PI byte → all outputs reach reset values immediately; a following full 'A' vector completes normally.
6. tx_ready held low 100 cycles during the 'F' reply → no tx_start until ready returns; all 3 bytes sent in order; preloading both counters to 0xFFFF and repeating a failing vector leaves both at 0xFFFF.
